ir_id_entry: RTL and testbench
==============================

# ir_id_entry

Keypad-entry stage directly downstream of the IR remote receiver. Consumes its single-cycle key pulses (digits 0-9, A = confirm, B = backspace, power = reset) and assembles a fixed-length BCD user ID. It exposes a live display buffer for the 7-segment driver. It hands the completed ID to the game/user-lookup logic over a valid/ready handshake.

## Interface
- MAX_DIGITS, 4, ID length in BCD digits (1..8)
- TIMEOUT_CYC, 500_000_000, idle cycles in ENTRY before auto-clear (10 s at 50 MHz)
- iCLK  in  1  system clock, 50 MHz
- iRST  in  1  reset, asynchronous, active-high
- iKEY_DIG  in  10  one-hot-ish digit pulses, bit n = key n (from o_0..o_9)
- iKEY_A  in  1  confirm pulse
- iKEY_B  in  1  backspace pulse
- iKEY_RST  in  1  power-key pulse, soft clear
- iID_READY  in  1  consumer accepts ID
- oID  out  4*MAX_DIGITS  latched BCD ID, most significant digit = first entered
- oID_VALID  out  1  ID available
- oDIGITS  out  4*MAX_DIGITS  display buffer; empty positions = 4'hF (blank)
- oCOUNT  out  4  digits currently entered
- oERR  out  1  one-cycle pulse: rejected key (overflow digit, short confirm)
- oTIMEOUT  out  1  one-cycle pulse: entry abandoned by timeout

## Operation
- States: IDLE (count 0), ENTRY (1..MAX_DIGITS digits), PRESENT (ID offered).
- Key priority within a cycle: iKEY_RST > iKEY_B > iKEY_A > digits; among multiple digit bits, lowest index wins. Only the winning key acts.
- Digit shift: buffer <= {buffer[4*MAX_DIGITS-5:0], d}; count+1. Backspace: buffer <= {4'hF, buffer[4*MAX_DIGITS-1:4]}; count-1.
- IDLE: digit -> shift, ENTRY. A or B -> ignored, no oERR.
- ENTRY, digit: count<MAX_DIGITS -> shift. Count==MAX_DIGITS -> ignored, oERR.
- ENTRY, B: backspace. Count reaching 0 -> IDLE.
- ENTRY, A: count==MAX_DIGITS -> oID<=buffer, oID_VALID<=1, PRESENT. Otherwise oERR, stay.
- ENTRY timeout: counter clears on any key pulse (accepted or not) and on entering ENTRY. When TIMEOUT_CYC cycles pass with no key: buffer all 4'hF, count 0, oTIMEOUT, IDLE.
- PRESENT: digits, A and B are ignored, no oERR. Transfer when oID_VALID && iID_READY. Then buffer blanked, count 0, oID_VALID<=0, IDLE. oID keeps its last value after the transfer.
- iKEY_RST in any state: buffer blank, count 0, oID_VALID 0, timeout counter 0, IDLE. No oERR. oID is not cleared.
- Reset values: oID 0, oID_VALID 0, oDIGITS all 4'hF, oCOUNT 0, oERR 0, oTIMEOUT 0, state IDLE.

## Timing
- All outputs registered. A key pulse sampled at edge t takes effect in oDIGITS, oCOUNT and the state at t+1.
- Confirm: A at t -> oID_VALID high and oID stable from t+1.
- oID_VALID and oID hold unchanged until the transfer edge. The consumer may hold iID_READY high permanently; the minimum PRESENT dwell is 1 cycle.
- Transfer edge t -> oID_VALID low and oDIGITS blank at t+1. A digit on cycle t+1 is accepted normally.
- oERR and oTIMEOUT are high exactly one cycle, at t+1 after the causing edge.
- Timeout counter is 32 bits and saturates; it counts only in ENTRY. The last key at edge t -> oTIMEOUT high at t+TIMEOUT_CYC+1.
- Asynchronous iRST mid-entry or mid-PRESENT forces the reset values immediately. The first key after deassertion is accepted.

## Test plan
- Test parameters: MAX_DIGITS=4, TIMEOUT_CYC=16.
- Enter 1,2,3,4 then A -> oDIGITS 16'h1234, oCOUNT 4. oID_VALID rises 1 cycle after A, oID 16'h1234. Raise iID_READY -> oID_VALID low next cycle, oDIGITS 16'hFFFF.
- Enter 5,6, B, 7 -> oDIGITS 16'hFF57, oCOUNT 2. A -> oERR pulse, state stays ENTRY. Enter 8,9, then 0 -> oERR pulse, oDIGITS 16'h5789 unchanged.
- Enter 3, wait 16 cycles with no key -> oTIMEOUT pulse, oDIGITS 16'hFFFF, oCOUNT 0. A key at cycle 15 restarts the count and prevents the timeout.
- Same-cycle iKEY_B + iKEY_DIG[4] with count 2 -> backspace only. Same-cycle digits 3 and 7 -> 3 shifted in.
- In PRESENT with iID_READY low: digits, A, B -> no change, no oERR. Then iKEY_RST -> oID_VALID 0 and IDLE next cycle, oID keeps 16'h1234.
- Assert iRST asynchronously mid-entry (count 3) -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/ir_id_entry.sv
// ir_id_entry
//   Keypad entry stage behind the IR remote receiver. It collects single-cycle
//   key pulses into a fixed-length BCD user ID, shows the digits typed so far
//   on a display buffer, and offers the finished ID to the user-lookup logic.
//
// Ports
//   iCLK, iRST     clock; asynchronous active-high reset
//   iKEY_DIG[9:0]  digit pulses, bit n = key n (lowest set bit wins)
//   iKEY_A         confirm pulse
//   iKEY_B         backspace pulse
//   iKEY_RST       power key: soft clear back to IDLE
//   iID_READY      consumer accepts the offered ID
//   oID            latched BCD ID, first entered digit in the top nibble
//   oID_VALID      ID on oID is being offered
//   oDIGITS        display buffer, unused positions read 4'hF (blank)
//   oCOUNT         number of digits currently entered
//   oERR           one-cycle pulse: rejected key
//   oTIMEOUT       one-cycle pulse: entry abandoned after TIMEOUT_CYC idle cycles
//   oSTATE         current FSM state (debug)
//
// Handshake: oID/oID_VALID form a valid/ready source. Once oID_VALID is high,
// oID and oID_VALID hold unchanged until an edge where iID_READY is also high;
// that edge is the transfer, after which oID_VALID drops. iID_READY may be
// held high permanently. Only iKEY_RST withdraws an offer without a transfer.
module ir_id_entry #(
    parameter int MAX_DIGITS  = 4,
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [9:0]              iKEY_DIG,
    input  logic                    iKEY_A,
    input  logic                    iKEY_B,
    input  logic                    iKEY_RST,
    input  logic                    iID_READY,
    output logic [4*MAX_DIGITS-1:0] oID,
    output logic                    oID_VALID,
    output logic [4*MAX_DIGITS-1:0] oDIGITS,
    output logic [3:0]              oCOUNT,
    output logic                    oERR,
    output logic                    oTIMEOUT,
    output logic [1:0]              oSTATE
);

    localparam int W = 4 * MAX_DIGITS;
    localparam logic [3:0]  MAX_CNT  = 4'(MAX_DIGITS);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [W-1:0] BLANK   = {W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   buf_q;
    logic [W-1:0]   id_q;
    logic [3:0]     cnt_q;
    logic           valid_q;
    logic           err_q;
    logic           to_q;
    logic [31:0]    tmo_q;

    logic           dig_hit;
    logic [3:0]     dig_val;
    logic           any_key;
    logic [W+3:0]   shl_wide;
    logic [W+3:0]   shr_wide;
    logic [W-1:0]   buf_shl;
    logic [W-1:0]   buf_shr;

    // Lowest-index digit wins: scan downwards so the last hit is the lowest.
    always_comb begin
        dig_val = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (iKEY_DIG[i]) dig_val = 4'(i);
        end
    end

    assign dig_hit = |iKEY_DIG;
    assign any_key = iKEY_RST | iKEY_B | iKEY_A | dig_hit;

    // Shifts built on a widened vector so MAX_DIGITS = 1 needs no special case.
    assign shl_wide = {buf_q, dig_val};
    assign shr_wide = {4'hF, buf_q};
    assign buf_shl  = shl_wide[W-1:0];
    assign buf_shr  = shr_wide[W+3:4];

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            buf_q   <= BLANK;
            id_q    <= '0;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            tmo_q   <= 32'd0;
        end else begin
            err_q <= 1'b0;
            to_q  <= 1'b0;

            // Idle counter: runs only in ENTRY, any key restarts it, saturates.
            if (any_key || state_q != ENTRY) begin
                tmo_q <= 32'd0;
            end else if (tmo_q != 32'hFFFF_FFFF) begin
                tmo_q <= tmo_q + 32'd1;
            end

            if (iKEY_RST) begin
                state_q <= IDLE;
                buf_q   <= BLANK;
                cnt_q   <= 4'd0;
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // A and B are silently ignored here; B/A still outrank digits.
                        if (!iKEY_B && !iKEY_A && dig_hit) begin
                            buf_q   <= buf_shl;
                            cnt_q   <= 4'd1;
                            state_q <= ENTRY;
                        end
                    end
                    ENTRY: begin
                        if (iKEY_B) begin
                            buf_q <= buf_shr;
                            cnt_q <= cnt_q - 4'd1;
                            if (cnt_q == 4'd1) state_q <= IDLE;
                        end else if (iKEY_A) begin
                            if (cnt_q == MAX_CNT) begin
                                id_q    <= buf_q;
                                valid_q <= 1'b1;
                                state_q <= PRESENT;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (dig_hit) begin
                            if (cnt_q < MAX_CNT) begin
                                buf_q <= buf_shl;
                                cnt_q <= cnt_q + 4'd1;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (tmo_q >= TMO_LAST) begin
                            buf_q   <= BLANK;
                            cnt_q   <= 4'd0;
                            to_q    <= 1'b1;
                            tmo_q   <= 32'd0;
                            state_q <= IDLE;
                        end
                    end
                    PRESENT: begin
                        // Keys other than power are ignored while the ID is offered.
                        if (valid_q && iID_READY) begin
                            buf_q   <= BLANK;
                            cnt_q   <= 4'd0;
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign oID       = id_q;
    assign oID_VALID = valid_q;
    assign oDIGITS   = buf_q;
    assign oCOUNT    = cnt_q;
    assign oERR      = err_q;
    assign oTIMEOUT  = to_q;
    assign oSTATE    = state_q;

endmodule

// File: tb/tb_ir_id_entry.sv
// tb_ir_id_entry
//   Directed-vector bench for ir_id_entry with MAX_DIGITS = 4 and
//   TIMEOUT_CYC = 16. Inputs change on the falling edge; outputs are checked
//   on the falling edge after the rising edge that sampled them.
module tb_ir_id_entry;

    localparam int MAX_DIGITS  = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ENTRY   = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;

    logic        iCLK;
    logic        iRST;
    logic [9:0]  iKEY_DIG;
    logic        iKEY_A;
    logic        iKEY_B;
    logic        iKEY_RST;
    logic        iID_READY;
    logic [15:0] oID;
    logic        oID_VALID;
    logic [15:0] oDIGITS;
    logic [3:0]  oCOUNT;
    logic        oERR;
    logic        oTIMEOUT;
    logic [1:0]  oSTATE;

    int n_checks = 0;
    int n_fail   = 0;

    ir_id_entry #(
        .MAX_DIGITS (MAX_DIGITS),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iKEY_DIG (iKEY_DIG),
        .iKEY_A   (iKEY_A),
        .iKEY_B   (iKEY_B),
        .iKEY_RST (iKEY_RST),
        .iID_READY(iID_READY),
        .oID      (oID),
        .oID_VALID(oID_VALID),
        .oDIGITS  (oDIGITS),
        .oCOUNT   (oCOUNT),
        .oERR     (oERR),
        .oTIMEOUT (oTIMEOUT),
        .oSTATE   (oSTATE)
    );

    // Clock and reset
    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    // Checking task
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks (called on a falling edge, return on the next falling edge)
    function automatic logic [9:0] dg(input int n);
        logic [9:0] one;
        one = 10'd1;
        return one << n;
    endfunction

    task automatic key(input logic [9:0] dig, input logic a, input logic b, input logic r);
        iKEY_DIG = dig;
        iKEY_A   = a;
        iKEY_B   = b;
        iKEY_RST = r;
        @(negedge iCLK);
        iKEY_DIG = '0;
        iKEY_A   = 1'b0;
        iKEY_B   = 1'b0;
        iKEY_RST = 1'b0;
    endtask

    task automatic digit(input int n);
        key(dg(n), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge iCLK);
    endtask

    initial begin
        iRST      = 1'b1;
        iKEY_DIG  = '0;
        iKEY_A    = 1'b0;
        iKEY_B    = 1'b0;
        iKEY_RST  = 1'b0;
        iID_READY = 1'b0;
        idle(2);

        // Reset values
        check("rst_id",      32'(oID),       32'h0);
        check("rst_valid",   32'(oID_VALID), 32'h0);
        check("rst_digits",  32'(oDIGITS),   32'hFFFF);
        check("rst_count",   32'(oCOUNT),    32'h0);
        check("rst_err",     32'(oERR),      32'h0);
        check("rst_timeout", 32'(oTIMEOUT),  32'h0);
        check("rst_state",   32'(oSTATE),    32'(S_IDLE));
        iRST = 1'b0;
        idle(1);

        // Full entry, confirm, transfer
        key('0, 1'b1, 1'b0, 1'b0);
        check("idle_a_err",  32'(oERR),   32'h0);
        check("idle_a_state",32'(oSTATE), 32'(S_IDLE));
        digit(1);
        check("d1_digits", 32'(oDIGITS), 32'hFFF1);
        check("d1_state",  32'(oSTATE),  32'(S_ENTRY));
        digit(2); digit(3); digit(4);
        check("d4_digits", 32'(oDIGITS), 32'h1234);
        check("d4_count",  32'(oCOUNT),  32'h4);
        check("pre_a_valid", 32'(oID_VALID), 32'h0);
        key('0, 1'b1, 1'b0, 1'b0);
        check("conf_valid", 32'(oID_VALID), 32'h1);
        check("conf_id",    32'(oID),       32'h1234);
        check("conf_state", 32'(oSTATE),    32'(S_PRESENT));
        check("conf_err",   32'(oERR),      32'h0);
        idle(1);
        check("hold_valid", 32'(oID_VALID), 32'h1);
        iID_READY = 1'b1;
        idle(1);
        iID_READY = 1'b0;
        check("xfer_valid",  32'(oID_VALID), 32'h0);
        check("xfer_digits", 32'(oDIGITS),   32'hFFFF);
        check("xfer_count",  32'(oCOUNT),    32'h0);
        check("xfer_id",     32'(oID),       32'h1234);
        check("xfer_state",  32'(oSTATE),    32'(S_IDLE));

        // Backspace, short confirm, overflow digit
        digit(5); digit(6);
        key('0, 1'b0, 1'b1, 1'b0);
        check("bs_digits", 32'(oDIGITS), 32'hFFF5);
        check("bs_count",  32'(oCOUNT),  32'h1);
        digit(7);
        check("d57_digits", 32'(oDIGITS), 32'hFF57);
        check("d57_count",  32'(oCOUNT),  32'h2);
        key('0, 1'b1, 1'b0, 1'b0);
        check("short_err",    32'(oERR),      32'h1);
        check("short_state",  32'(oSTATE),    32'(S_ENTRY));
        check("short_valid",  32'(oID_VALID), 32'h0);
        check("short_digits", 32'(oDIGITS),   32'hFF57);
        idle(1);
        check("err_pulse_end", 32'(oERR), 32'h0);
        digit(8); digit(9);
        check("d5789_digits", 32'(oDIGITS), 32'h5789);
        digit(0);
        check("ovf_err",    32'(oERR),    32'h1);
        check("ovf_digits", 32'(oDIGITS), 32'h5789);
        check("ovf_count",  32'(oCOUNT),  32'h4);
        key('0, 1'b0, 1'b0, 1'b1);
        check("soft_digits", 32'(oDIGITS), 32'hFFFF);
        check("soft_state",  32'(oSTATE),  32'(S_IDLE));
        check("soft_err",    32'(oERR),    32'h0);

        // Backspace down to empty returns to IDLE
        digit(6);
        key('0, 1'b0, 1'b1, 1'b0);
        check("bs0_count", 32'(oCOUNT), 32'h0);
        check("bs0_state", 32'(oSTATE), 32'(S_IDLE));

        // Timeout after 16 key-free cycles
        digit(3);
        idle(TIMEOUT_CYC - 1);
        check("tmo_early",       32'(oTIMEOUT), 32'h0);
        check("tmo_early_count", 32'(oCOUNT),   32'h1);
        idle(1);
        check("tmo_pulse",  32'(oTIMEOUT), 32'h1);
        check("tmo_digits", 32'(oDIGITS),  32'hFFFF);
        check("tmo_count",  32'(oCOUNT),   32'h0);
        check("tmo_state",  32'(oSTATE),   32'(S_IDLE));
        idle(1);
        check("tmo_pulse_end", 32'(oTIMEOUT), 32'h0);

        // Key at cycle 15 restarts the idle count
        digit(3);
        idle(TIMEOUT_CYC - 2);
        digit(4);
        check("rst_tmo_digits", 32'(oDIGITS),  32'hFF34);
        check("rst_tmo_none",   32'(oTIMEOUT), 32'h0);
        idle(TIMEOUT_CYC - 1);
        check("rst_tmo_early", 32'(oTIMEOUT), 32'h0);
        check("rst_tmo_count", 32'(oCOUNT),   32'h2);
        idle(1);
        check("rst_tmo_pulse", 32'(oTIMEOUT), 32'h1);

        // Same-cycle key priority
        digit(1); digit(2);
        key(dg(4), 1'b0, 1'b1, 1'b0);
        check("prio_bs_digits", 32'(oDIGITS), 32'hFFF1);
        check("prio_bs_count",  32'(oCOUNT),  32'h1);
        key(dg(3) | dg(7), 1'b0, 1'b0, 1'b0);
        check("prio_low_digits", 32'(oDIGITS), 32'hFF13);
        key(dg(9), 1'b1, 1'b0, 1'b0);
        check("prio_a_err",    32'(oERR),    32'h1);
        check("prio_a_digits", 32'(oDIGITS), 32'hFF13);
        key(dg(5), 1'b1, 1'b1, 1'b1);
        check("prio_rst_digits", 32'(oDIGITS), 32'hFFFF);
        check("prio_rst_err",    32'(oERR),    32'h0);

        // PRESENT ignores digits/A/B, power key withdraws the offer
        digit(1); digit(2); digit(3); digit(4);
        key('0, 1'b1, 1'b0, 1'b0);
        digit(5);
        check("pres_d_digits", 32'(oDIGITS),   32'h1234);
        check("pres_d_err",    32'(oERR),      32'h0);
        check("pres_d_valid",  32'(oID_VALID), 32'h1);
        key('0, 1'b1, 1'b0, 1'b0);
        check("pres_a_err",   32'(oERR),   32'h0);
        check("pres_a_state", 32'(oSTATE), 32'(S_PRESENT));
        key('0, 1'b0, 1'b1, 1'b0);
        check("pres_b_digits", 32'(oDIGITS), 32'h1234);
        check("pres_b_count",  32'(oCOUNT),  32'h4);
        key('0, 1'b0, 1'b0, 1'b1);
        check("pres_rst_valid", 32'(oID_VALID), 32'h0);
        check("pres_rst_state", 32'(oSTATE),    32'(S_IDLE));
        check("pres_rst_id",    32'(oID),       32'h1234);
        check("pres_rst_err",   32'(oERR),      32'h0);

        // Ready held high: one-cycle PRESENT dwell, next digit accepted
        iID_READY = 1'b1;
        digit(8); digit(7); digit(6); digit(5);
        key('0, 1'b1, 1'b0, 1'b0);
        check("rdy_valid", 32'(oID_VALID), 32'h1);
        check("rdy_id",    32'(oID),       32'h8765);
        digit(2);
        check("rdy_xfer_valid", 32'(oID_VALID), 32'h0);
        check("rdy_xfer_digits", 32'(oDIGITS),  32'hFFFF);
        digit(2);
        check("rdy_next_digits", 32'(oDIGITS), 32'hFFF2);
        check("rdy_next_count",  32'(oCOUNT),  32'h1);
        iID_READY = 1'b0;
        key('0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-entry
        digit(9); digit(8); digit(7);
        check("pre_arst_count", 32'(oCOUNT), 32'h3);
        #2 iRST = 1'b1;
        #1;
        check("arst_digits", 32'(oDIGITS),   32'hFFFF);
        check("arst_count",  32'(oCOUNT),    32'h0);
        check("arst_valid",  32'(oID_VALID), 32'h0);
        check("arst_id",     32'(oID),       32'h0);
        check("arst_state",  32'(oSTATE),    32'(S_IDLE));
        check("arst_err",    32'(oERR),      32'h0);
        check("arst_tmo",    32'(oTIMEOUT),  32'h0);
        @(negedge iCLK);
        iRST = 1'b0;
        digit(6);
        check("post_arst_digits", 32'(oDIGITS), 32'hFFF6);
        check("post_arst_count",  32'(oCOUNT),  32'h1);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
